ibex_imem_responder: RTL and testbench

IBEX_IMEM_RESPONDER -- requirements
Module: ibex_imem_responder

---
 rtl/ibex_imem_responder.sv | 123 ++++++++++++
 tb/tb_ibex_imem_responder.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_imem_responder.sv
// Instruction-memory responder for an Ibex-style fetch port: word array with a
// program-load port, fixed-latency in-order responses, outstanding limit and periodic stalls.
module ibex_imem_responder #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned LATENCY      = 1,
    parameter int unsigned MAX_OUTST    = 2,
    parameter int unsigned STALL_PERIOD = 0,
    parameter bit          ERR_OOR      = 1'b1,
    localparam int unsigned AW          = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          instr_req_i,
    input  logic [31:0]   instr_addr_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    output logic [31:0]   instr_rdata_o,
    output logic          instr_err_o,
    input  logic          prog_we_i,
    input  logic [AW-1:0] prog_addr_i,
    input  logic [31:0]   prog_wdata_i,
    output logic [31:0]   grant_cnt_o
);
    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam int unsigned OW         = $clog2(MAX_OUTST + 1);
    localparam int unsigned SW         = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam int unsigned STALL_LAST = (STALL_PERIOD == 0) ? 0 : STALL_PERIOD - 1;

    logic [31:0]   mem [DEPTH];
    logic [OW-1:0] outstanding;
    logic [SW-1:0] stall_cnt;
    logic          stall_slot;

    logic [AW-1:0] fetch_idx;
    logic          fetch_oor;
    logic          fetch_err;
    logic [31:0]   fetch_data;
    logic          unused_addr;

    logic [LATENCY-1:0] pipe_valid;
    logic [LATENCY-1:0] pipe_err;
    logic [31:0]        pipe_data [LATENCY];

    assign stall_slot  = (STALL_PERIOD != 0) && (stall_cnt == SW'(STALL_LAST));
    assign instr_gnt_o = instr_req_i & ~rst_i & (outstanding < OW'(MAX_OUTST)) & ~stall_slot;

    // Byte-offset bits carry no meaning for word fetches.
    assign unused_addr = ^instr_addr_i[1:0];
    assign fetch_idx   = instr_addr_i[2 +: AW];
    assign fetch_oor   = |instr_addr_i[31:AW+2];
    assign fetch_err   = ERR_OOR && fetch_oor;
    assign fetch_data  = fetch_err ? 32'h0 : mem[fetch_idx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the array reset is real behaviour (every word becomes a NOP), so it
            // cannot map to a plain RAM macro; it is a register file by intent.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= NOP;
            end
        end else if (prog_we_i) begin
            mem[prog_addr_i] <= prog_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (stall_cnt == SW'(STALL_LAST)) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Stage 0 is loaded at the grant edge; data and err are zeroed in empty slots so
    // the output stage is already clean when rvalid is low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage shift from the old
            // value of its predecessor regardless of statement order.
            pipe_valid[0] <= instr_gnt_o;
            pipe_err[0]   <= instr_gnt_o & fetch_err;
            pipe_data[0]  <= instr_gnt_o ? fetch_data : 32'h0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    assign instr_rvalid_o = pipe_valid[LATENCY-1];
    assign instr_err_o    = pipe_err[LATENCY-1];
    assign instr_rdata_o  = pipe_data[LATENCY-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding <= '0;
        end else begin
            case ({instr_gnt_o, instr_rvalid_o})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_cnt_o <= '0;
        end else if (instr_gnt_o && (grant_cnt_o != 32'hFFFF_FFFF)) begin
            grant_cnt_o <= grant_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_ibex_imem_responder.sv
// Bench for ibex_imem_responder: four configurations on one clock, each compared every
// cycle against a queue-based transaction model plus fixed expectations for key scenarios.
module tb_ibex_imem_responder;
    localparam int N = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Per-instance configuration: 0 default, 1 LATENCY=3, 2 STALL_PERIOD=4, 3 LATENCY=2 aliasing.
    int lat_m [N] = '{1, 3, 1, 2};
    int mo_m  [N] = '{2, 2, 2, 2};
    int sp_m  [N] = '{0, 0, 4, 0};
    int eo_m  [N] = '{1, 1, 1, 0};

    logic        clk = 1'b0;
    logic        rst;
    logic        req [N];
    logic [31:0] addr [N];
    logic        we [N];
    logic [2:0]  pa [N];
    logic [31:0] pd [N];
    logic        gnt [N];
    logic        rv [N];
    logic        er [N];
    logic [31:0] rd [N];
    logic [31:0] gc [N];

    typedef struct packed {
        int          due;
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic [31:0] mem_m [N][8];
    resp_t       pend [N][$];
    logic [31:0] gc_m [N];
    logic        e_gnt [N];
    logic        e_rv [N];
    logic        e_er [N];
    logic [31:0] e_rd [N];
    logic [31:0] e_gc [N];
    int          t_m;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    ibex_imem_responder #(.DEPTH(8), .LATENCY(1), .MAX_OUTST(2), .STALL_PERIOD(0), .ERR_OOR(1'b1)) u_def (
        .clk_i(clk), .rst_i(rst), .instr_req_i(req[0]), .instr_addr_i(addr[0]),
        .instr_gnt_o(gnt[0]), .instr_rvalid_o(rv[0]), .instr_rdata_o(rd[0]), .instr_err_o(er[0]),
        .prog_we_i(we[0]), .prog_addr_i(pa[0]), .prog_wdata_i(pd[0]), .grant_cnt_o(gc[0]));

    ibex_imem_responder #(.DEPTH(8), .LATENCY(3), .MAX_OUTST(2), .STALL_PERIOD(0), .ERR_OOR(1'b1)) u_lat3 (
        .clk_i(clk), .rst_i(rst), .instr_req_i(req[1]), .instr_addr_i(addr[1]),
        .instr_gnt_o(gnt[1]), .instr_rvalid_o(rv[1]), .instr_rdata_o(rd[1]), .instr_err_o(er[1]),
        .prog_we_i(we[1]), .prog_addr_i(pa[1]), .prog_wdata_i(pd[1]), .grant_cnt_o(gc[1]));

    ibex_imem_responder #(.DEPTH(8), .LATENCY(1), .MAX_OUTST(2), .STALL_PERIOD(4), .ERR_OOR(1'b1)) u_stall (
        .clk_i(clk), .rst_i(rst), .instr_req_i(req[2]), .instr_addr_i(addr[2]),
        .instr_gnt_o(gnt[2]), .instr_rvalid_o(rv[2]), .instr_rdata_o(rd[2]), .instr_err_o(er[2]),
        .prog_we_i(we[2]), .prog_addr_i(pa[2]), .prog_wdata_i(pd[2]), .grant_cnt_o(gc[2]));

    ibex_imem_responder #(.DEPTH(8), .LATENCY(2), .MAX_OUTST(2), .STALL_PERIOD(0), .ERR_OOR(1'b0)) u_alias (
        .clk_i(clk), .rst_i(rst), .instr_req_i(req[3]), .instr_addr_i(addr[3]),
        .instr_gnt_o(gnt[3]), .instr_rvalid_o(rv[3]), .instr_rdata_o(rd[3]), .instr_err_o(er[3]),
        .prog_we_i(we[3]), .prog_addr_i(pa[3]), .prog_wdata_i(pd[3]), .grant_cnt_o(gc[3]));

    function automatic logic [66:0] obs(int d);
        return {gnt[d], rv[d], er[d], rd[d], gc[d]};
    endfunction

    function automatic logic [66:0] expv(int d);
        return {e_gnt[d], e_rv[d], e_er[d], e_rd[d], e_gc[d]};
    endfunction

    // Expected outputs for the current cycle. A request is in flight from its grant
    // until the cycle after its response, which bounds how many grants may be pending.
    task automatic predict();
        bit stall;
        for (int d = 0; d < N; d++) begin
            stall    = (sp_m[d] != 0) && ((t_m % sp_m[d]) == sp_m[d] - 1);
            e_gnt[d] = req[d] && !rst && (pend[d].size() < mo_m[d]) && !stall;
            e_rv[d]  = 1'b0;
            e_er[d]  = 1'b0;
            e_rd[d]  = 32'h0;
            if (pend[d].size() > 0 && pend[d][0].due == t_m) begin
                e_rv[d] = 1'b1;
                e_er[d] = pend[d][0].err;
                e_rd[d] = pend[d][0].data;
            end
            e_gc[d] = gc_m[d];
        end
    endtask

    // Apply the clock edge to the model: retire, issue, count, then program-load write.
    task automatic advance();
        resp_t       r;
        logic [31:0] a;
        @(posedge clk);
        for (int d = 0; d < N; d++) begin
            if (rst) begin
                pend[d].delete();
                for (int k = 0; k < 8; k++) mem_m[d][k] = NOP;
                gc_m[d] = 32'h0;
            end else begin
                if (e_rv[d]) void'(pend[d].pop_front());
                if (e_gnt[d]) begin
                    a     = addr[d];
                    r.due = t_m + lat_m[d];
                    if (eo_m[d] != 0 && a >= 32) begin
                        r.data = 32'h0;
                        r.err  = 1'b1;
                    end else begin
                        r.data = mem_m[d][(a >> 2) % 8];
                        r.err  = 1'b0;
                    end
                    pend[d].push_back(r);
                    if (gc_m[d] != 32'hFFFF_FFFF) gc_m[d] = gc_m[d] + 1;
                end
                if (we[d]) mem_m[d][pa[d]] = pd[d];
            end
        end
        if (rst) t_m = 0;
        else     t_m = t_m + 1;
        #1;
    endtask

    task automatic idle_all();
        for (int d = 0; d < N; d++) begin
            req[d]  = 1'b0;
            addr[d] = 32'h0;
            we[d]   = 1'b0;
            pa[d]   = 3'd0;
            pd[d]   = 32'h0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < N; d++) req[d] = 1'b1;
        @(negedge clk); predict(); advance();
        @(negedge clk); predict();
        for (int d = 0; d < N; d++) begin
            checks++;
            if (obs(d) !== expv(d)) begin
                errors++;
                $display("FAIL reset dut=%0d got=%h exp=%h", d, obs(d), expv(d));
            end
        end
        advance();
        rst = 1'b0;
        idle_all();
    endtask

    task automatic test_nop_fetch();
        for (int c = 0; c < 5; c++) begin
            req[0]  = (c < 3);
            addr[0] = 32'(4 * c);
            @(negedge clk); predict();
            checks++;
            if (obs(0) !== expv(0)) begin
                errors++;
                $display("FAIL nop_fetch cyc=%0d got=%h exp=%h", c, obs(0), expv(0));
            end
            if (c >= 1 && c <= 3) begin
                checks++;
                if ({rv[0], er[0], rd[0]} !== {2'b10, NOP}) begin
                    errors++;
                    $display("FAIL nop_data cyc=%0d got=%b%b_%h exp=10_%h", c, rv[0], er[0], rd[0], NOP);
                end
            end
            advance();
        end
        idle_all();
    endtask

    task automatic test_prog_write();
        logic [31:0] newval;
        logic [31:0] want;
        newval = 32'h3B16_9073 ^ ($urandom() | 32'h1);
        for (int c = 0; c < 5; c++) begin
            req[0]  = (c >= 1 && c <= 3);
            addr[0] = 32'h1C;
            we[0]   = (c == 0 || c == 2);
            pa[0]   = 3'd7;
            pd[0]   = (c == 0) ? 32'h3B16_9073 : newval;
            @(negedge clk); predict();
            checks++;
            if (obs(0) !== expv(0)) begin
                errors++;
                $display("FAIL prog_write cyc=%0d got=%h exp=%h", c, obs(0), expv(0));
            end
            if (c >= 2) begin
                want = (c == 4) ? newval : 32'h3B16_9073;
                checks++;
                if ({rv[0], rd[0]} !== {1'b1, want}) begin
                    errors++;
                    $display("FAIL prog_data cyc=%0d got=%b_%h exp=1_%h", c, rv[0], rd[0], want);
                end
            end
            advance();
        end
        idle_all();
    endtask

    task automatic test_max_outst();
        logic ghist [24];
        for (int c = 0; c < 24; c++) begin
            req[1]  = (c < 18);
            addr[1] = 32'($urandom_range(0, 7) * 4);
            @(negedge clk); predict();
            ghist[c] = gnt[1];
            checks++;
            if (obs(1) !== expv(1)) begin
                errors++;
                $display("FAIL max_outst cyc=%0d got=%h exp=%h", c, obs(1), expv(1));
            end
            if (c >= 3) begin
                checks++;
                if (rv[1] !== ghist[c-3]) begin
                    errors++;
                    $display("FAIL lat3_rvalid cyc=%0d got=%b exp=%b", c, rv[1], ghist[c-3]);
                end
            end
            advance();
        end
        idle_all();
    endtask

    task automatic test_stall();
        rst = 1'b1;
        @(negedge clk); predict(); advance();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            req[2]  = 1'b1;
            addr[2] = 32'($urandom_range(0, 7) * 4);
            @(negedge clk); predict();
            checks++;
            if (obs(2) !== expv(2)) begin
                errors++;
                $display("FAIL stall cyc=%0d got=%h exp=%h", c, obs(2), expv(2));
            end
            checks++;
            if (gnt[2] !== ((c % 4) != 3)) begin
                errors++;
                $display("FAIL stall_gnt cyc=%0d got=%b exp=%b", c, gnt[2], ((c % 4) != 3));
            end
            advance();
        end
        idle_all();
        @(negedge clk); predict();
        checks++;
        if (gc[2] !== 32'd9) begin
            errors++;
            $display("FAIL stall_grant_cnt got=%0d exp=9", gc[2]);
        end
        advance();
    endtask

    task automatic test_oor(output logic [31:0] w0);
        w0 = $urandom() | 32'h8000_0000;
        for (int c = 0; c < 5; c++) begin
            we[3]   = (c == 0);
            pa[3]   = 3'd0;
            pd[3]   = w0;
            req[0]  = (c == 1);
            req[3]  = (c == 1);
            addr[0] = 32'h20;
            addr[3] = 32'h20;
            @(negedge clk); predict();
            for (int d = 0; d < N; d += 3) begin
                checks++;
                if (obs(d) !== expv(d)) begin
                    errors++;
                    $display("FAIL oor dut=%0d cyc=%0d got=%h exp=%h", d, c, obs(d), expv(d));
                end
            end
            if (c == 2) begin
                checks++;
                if ({rv[0], er[0], rd[0]} !== {2'b11, 32'h0}) begin
                    errors++;
                    $display("FAIL oor_err got=%b%b_%h exp=11_00000000", rv[0], er[0], rd[0]);
                end
            end
            if (c == 3) begin
                checks++;
                if ({rv[3], er[3], rd[3]} !== {2'b10, w0}) begin
                    errors++;
                    $display("FAIL oor_alias got=%b%b_%h exp=10_%h", rv[3], er[3], rd[3], w0);
                end
            end
            advance();
        end
        idle_all();
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < 7; c++) begin
            rst     = (c == 1);
            req[3]  = (c == 0 || c == 3);
            addr[3] = 32'h0;
            @(negedge clk); predict();
            checks++;
            if (obs(3) !== expv(3)) begin
                errors++;
                $display("FAIL reset_mid cyc=%0d got=%h exp=%h", c, obs(3), expv(3));
            end
            if (c == 2 || c == 3) begin
                checks++;
                if (rv[3] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_mid_rvalid cyc=%0d got=%b exp=0", c, rv[3]);
                end
            end
            if (c == 5) begin
                checks++;
                if ({rv[3], er[3], rd[3]} !== {2'b10, NOP}) begin
                    errors++;
                    $display("FAIL reset_mid_nop got=%b%b_%h exp=10_%h", rv[3], er[3], rd[3], NOP);
                end
            end
            advance();
        end
        rst = 1'b0;
        idle_all();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int d = 0; d < N; d++) begin
                req[d]  = ($urandom_range(0, 3) != 0);
                addr[d] = ($urandom_range(0, 9) == 0) ? $urandom()
                                                      : 32'($urandom_range(0, 11) * 4 + $urandom_range(0, 3));
                we[d]   = ($urandom_range(0, 3) == 0);
                pa[d]   = 3'($urandom_range(0, 7));
                pd[d]   = $urandom();
            end
            @(negedge clk); predict();
            for (int d = 0; d < N; d++) begin
                checks++;
                if (obs(d) !== expv(d)) begin
                    errors++;
                    $display("FAIL random dut=%0d cyc=%0d got=%h exp=%h", d, c, obs(d), expv(d));
                end
            end
            advance();
        end
        rst = 1'b0;
        idle_all();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); predict();
            for (int d = 0; d < N; d++) begin
                checks++;
                if (obs(d) !== expv(d)) begin
                    errors++;
                    $display("FAIL drain dut=%0d cyc=%0d got=%h exp=%h", d, c, obs(d), expv(d));
                end
            end
            advance();
        end
    endtask

    initial begin
        logic [31:0] w0;
        rst = 1'b1;
        t_m = 0;
        idle_all();
        for (int d = 0; d < N; d++) gc_m[d] = 32'h0;
        #1;
        test_reset();
        test_nop_fetch();
        test_prog_write();
        test_max_outst();
        test_stall();
        test_oor(w0);
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
